// File: rtl/ysyx_23060124_ifu_if.sv
// ysyx_23060124_ifu_if: IFU bus bundle.
// AR/R read channel to memory plus the fetch handoff to decode.
interface ysyx_23060124_ifu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] ins;
  logic [ADDR_W-1:0] pc;
  logic              fault;
  logic              post_valid;
  logic              post_ready;

  modport master (
    output araddr, arvalid, rready,
    output ins, pc, fault, post_valid,
    input  arready, rdata, rresp, rvalid,
    input  post_ready
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  ins, pc, fault, post_valid,
    output arready, rdata, rresp, rvalid,
    output post_ready
  );
endinterface

// File: rtl/ysyx_23060124_ifu.sv
// ysyx_23060124_ifu: multi-cycle instruction fetch unit.
// Ports: clock/i_rst_n, WB pc update, bus (AR/R + decode handoff), o_fetch_cnt.
module ysyx_23060124_ifu #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc_next,
  input  logic              i_pc_update,
  ysyx_23060124_ifu_if.master bus,
  output logic [31:0]       o_fetch_cnt
);

  typedef enum logic [1:0] {
    REQ, RESP, HOLD, WAIT_WB
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ins_q, ins_d;
  logic              fault_q, fault_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              post_valid_q, post_valid_d;

  logic ar_hs;
  logic r_hs;
  logic post_hs;
  logic misaligned;

  assign ar_hs      = arvalid_q & bus.arready;
  assign r_hs       = rready_q & bus.rvalid;
  assign post_hs    = post_valid_q & bus.post_ready;
  assign misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    fault_d     = fault_q;
    fetch_cnt_d = fetch_cnt_q;
    unique case (state_q)
      REQ: begin
        if (misaligned) begin
          ins_d   = '0;
          fault_d = 1'b1;
          state_d = HOLD;
        end else if (ar_hs) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (r_hs) begin
          ins_d   = (bus.rresp == 2'b00) ? bus.rdata : '0;
          fault_d = (bus.rresp != 2'b00);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (post_hs) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = WAIT_WB;
        end
      end
      WAIT_WB: begin
        if (i_pc_update) begin
          pc_d    = i_pc_next;
          state_d = REQ;
        end
      end
    endcase
  end

  // Handshake outputs follow the next state so they are plain flops;
  // a misaligned pc never raises arvalid.
  always_comb begin
    arvalid_d    = (state_d == REQ) && (pc_d[1:0] == 2'b00);
    rready_d     = (state_d == RESP);
    post_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      ins_q        <= '0;
      fault_q      <= 1'b0;
      fetch_cnt_q  <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      post_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ins_q        <= ins_d;
      fault_q      <= fault_d;
      fetch_cnt_q  <= fetch_cnt_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      post_valid_q <= post_valid_d;
    end
  end

  assign bus.araddr     = pc_q;
  assign bus.arvalid    = arvalid_q;
  assign bus.rready     = rready_q;
  assign bus.ins        = ins_q;
  assign bus.pc         = pc_q;
  assign bus.fault      = fault_q;
  assign bus.post_valid = post_valid_q;
  assign o_fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// tb_ysyx_23060124_ifu: directed + random fetch loop against
// a transaction-level model of pc, fault, instruction and count.
module tb_ysyx_23060124_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_pc_next;
  logic        i_pc_update;
  logic [31:0] o_fetch_cnt;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int t_upd = 0;

  logic [31:0] pc_m;
  logic [31:0] cnt_m;

  ysyx_23060124_ifu_if bus ();

  ysyx_23060124_ifu dut (
    .clock       (clock),
    .i_rst_n     (i_rst_n),
    .i_pc_next   (i_pc_next),
    .i_pc_update (i_pc_update),
    .bus         (bus),
    .o_fetch_cnt (o_fetch_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic pulse(input logic [31:0] v);
    i_pc_next   = v;
    i_pc_update = 1'b1;
    t_upd       = cyc;
    @(negedge clock);
    i_pc_update = 1'b0;
    i_pc_next   = $urandom;
    pc_m        = v;
  endtask

  task automatic do_fetch(input int aw, input int rw, input int pw,
                          input logic [1:0] resp,
                          input logic [31:0] data,
                          input bit spur, input bit wrap,
                          output int lat);
    logic [31:0] pc;
    bit          al;
    logic [31:0] e_ins;
    bit          e_flt;
    int          n;
    pc    = pc_m;
    al    = (pc_m[1:0] == 2'b00);
    e_ins = (al && resp == 2'b00) ? data : 32'h0;
    e_flt = !al || (resp != 2'b00);
    n     = 0;
    if (al) begin
      while (!bus.arvalid && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("ar_valid", bus.arvalid, 1);
      chk("ar_addr", bus.araddr, pc);
      for (int i = 0; i < aw; i++) begin
        @(negedge clock);
        chk("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, pc});
      end
      bus.arready = 1'b1;
      @(negedge clock);
      bus.arready = 1'b0;
      if (spur) begin
        i_pc_next   = ~pc;
        i_pc_update = 1'b1;
        @(negedge clock);
        i_pc_update = 1'b0;
      end
      for (int i = 0; i < rw; i++) begin
        chk("r_ready", bus.rready, 1);
        @(negedge clock);
      end
      chk("r_ready", bus.rready, 1);
      bus.rvalid = 1'b1;
      bus.rdata  = data;
      bus.rresp  = resp;
      @(negedge clock);
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      bus.rresp  = 2'($urandom);
    end
    n = 0;
    while (!bus.post_valid && n < 20) begin
      if (!al) chk("no_ar", bus.arvalid, 0);
      @(negedge clock);
      n++;
    end
    lat = cyc - t_upd;
    chk("post_valid", bus.post_valid, 1);
    chk("ins", bus.ins, e_ins);
    chk("pc", bus.pc, pc);
    chk("fault", bus.fault, e_flt);
    chk("cnt_hold", o_fetch_cnt, cnt_m);
    if (wrap) begin
      force dut.fetch_cnt_q = 32'hFFFF_FFFF;
      @(negedge clock);
      release dut.fetch_cnt_q;
      cnt_m = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < pw; i++) begin
      @(negedge clock);
      chk("hold_v", bus.post_valid, 1);
      chk("hold_ins", bus.ins, e_ins);
      chk("hold_pf", {bus.pc, bus.fault}, {pc, e_flt});
    end
    bus.post_ready = 1'b1;
    @(negedge clock);
    bus.post_ready = 1'b0;
    cnt_m = cnt_m + 32'd1;
    chk("post_done", bus.post_valid, 0);
    chk("cnt", o_fetch_cnt, cnt_m);
  endtask

  initial begin
    int          lat;
    int          aw;
    int          rw;
    int          pw;
    logic [31:0] nx;
    logic [1:0]  rs;

    i_rst_n        = 1'b0;
    i_pc_next      = '0;
    i_pc_update    = 1'b0;
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b0;
    bus.rdata      = '0;
    bus.rresp      = 2'b00;
    bus.post_ready = 1'b0;
    pc_m           = RST_PC;
    cnt_m          = '0;

    repeat (3) @(negedge clock);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_pvalid", bus.post_valid, 0);
    chk("rst_ins", bus.ins, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_cnt", o_fetch_cnt, 0);
    chk("rst_addr", bus.araddr, RST_PC);
    i_rst_n = 1'b1;

    do_fetch(0, 0, 0, 2'b00, 32'h0000_0413, 0, 0, lat);

    pulse(32'h8000_0010);
    chk("next_ar_v", bus.arvalid, 1);
    chk("next_ar_a", bus.araddr, 32'h8000_0010);
    do_fetch(0, 0, 0, 2'b00, 32'h0010_0093, 0, 0, lat);
    chk("lat_zero_wait", lat, 3);

    pulse(32'h8000_0020);
    do_fetch(4, 3, 5, 2'b00, 32'h0020_8113, 0, 0, lat);
    chk("lat_waits", lat, 10);

    pulse(32'h8000_0006);
    do_fetch(0, 0, 0, 2'b00, 32'h0, 0, 0, lat);
    chk("lat_misalign", lat, 2);

    pulse(32'h8000_0030);
    do_fetch(0, 1, 1, 2'b10, 32'hDEAD_BEEF, 1, 0, lat);

    pulse(32'h8000_0040);
    chk("rst_pre_ar", bus.arvalid, 1);
    bus.arready = 1'b1;
    @(negedge clock);
    bus.arready = 1'b0;
    chk("rst_pre_resp", bus.rready, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_arvalid", bus.arvalid, 0);
    chk("arst_rready", bus.rready, 0);
    chk("arst_pvalid", bus.post_valid, 0);
    chk("arst_ins", bus.ins, 0);
    chk("arst_fault", bus.fault, 0);
    chk("arst_cnt", o_fetch_cnt, 0);
    chk("arst_pc", bus.pc, RST_PC);
    repeat (2) @(negedge clock);
    i_rst_n = 1'b1;
    cnt_m   = '0;
    pc_m    = RST_PC;
    do_fetch(1, 0, 0, 2'b00, 32'h1234_5678, 0, 0, lat);

    pulse(32'h8000_0050);
    do_fetch(0, 0, 1, 2'b00, 32'h0000_0013, 0, 1, lat);

    for (int k = 0; k < 25; k++) begin
      nx = RST_PC + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 5) == 0) nx[1:0] = 2'($urandom_range(1, 3));
      aw = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      pw = $urandom_range(0, 3);
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clock);
        chk("wb_idle", {bus.arvalid, bus.post_valid}, 0);
      end
      pulse(nx);
      do_fetch(aw, rw, pw, rs, $urandom, 0, 0, lat);
      chk("lat_rand", lat, (nx[1:0] == 2'b00) ? 3 + aw + rw : 2);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
